// File: rtl/day2_pkg.sv
// Shared types and ASCII constants for the day 2 range loader.
package day2_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        PARSE_START = 3'd1,
        PARSE_END   = 3'd2,
        FINISH      = 3'd3,
        RUN         = 3'd4
    } loader_state_t;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_DASH  = 8'h2D;
    localparam logic [7:0] CH_COMMA = 8'h2C;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SP    = 8'h20;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= CH_0) && (b <= CH_9);
    endfunction

endpackage

// File: rtl/day2_dec_accum.sv
// W-bit decimal shift-accumulator: acc = acc*10 + digit, with clear and a
// flag telling whether any digit has arrived since the last clear.
module day2_dec_accum #(
    parameter int W = 48
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         digit_valid_i,
    input  logic [3:0]   digit_i,
    output logic [W-1:0] acc_o,
    output logic [W-1:0] acc_nxt_o,
    output logic         has_digits_o
);

    logic [W-1:0] acc_q, acc_d;
    logic         has_digits_q, has_digits_d;

    // acc*10 as two shifts; wraps silently modulo 2^W.
    assign acc_nxt_o = (acc_q << 3) + (acc_q << 1) + W'(digit_i);

    always_comb begin
        acc_d        = acc_q;
        has_digits_d = has_digits_q;
        if (clear_i) begin
            acc_d        = '0;
            has_digits_d = 1'b0;
        end else if (digit_valid_i) begin
            acc_d        = acc_nxt_o;
            has_digits_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q        <= '0;
            has_digits_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            has_digits_q <= has_digits_d;
        end
    end

    assign acc_o        = acc_q;
    assign has_digits_o = has_digits_q;

endmodule

// File: rtl/day2_range_loader.sv
// Parses "a-b,c-d,..." from a byte stream into start_id/end_id slot arrays,
// then drives the load-then-enable sequence for day2_puzzle.
module day2_range_loader
    import day2_pkg::*;
#(
    parameter int W         = 48,
    parameter int NUM_UNITS = 38,
    parameter int CNT_W     = $clog2(NUM_UNITS + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic [W-1:0]     start_id [NUM_UNITS],
    output logic [W-1:0]     end_id   [NUM_UNITS],
    output logic             load,
    output logic             en,
    output logic [CNT_W-1:0] range_count,
    output logic             error
);

    // Handshake: a byte transfers on a rising edge where in_valid && in_ready.
    // in_ready depends only on the current state, never on in_valid.

    loader_state_t    state_q, state_d, state_p;
    logic             in_ready_q, in_ready_d;
    logic             load_q, load_d;
    logic             en_q, en_d;
    logic             error_q, error_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [W-1:0]     start_save_q, start_save_d;
    logic [W-1:0]     start_id_q [NUM_UNITS];
    logic [W-1:0]     end_id_q   [NUM_UNITS];

    logic             accept, b_digit, b_dash, b_delim, b_ignore;
    logic             acc_clear, digit_v, hd_p, commit, wr_en;
    logic [W-1:0]     commit_end, acc, acc_nxt;
    logic             has_digits;

    day2_dec_accum #(.W(W)) u_accum (
        .clock         (clock),
        .reset         (reset),
        .clear_i       (acc_clear),
        .digit_valid_i (digit_v),
        .digit_i       (in_data[3:0]),
        .acc_o         (acc),
        .acc_nxt_o     (acc_nxt),
        .has_digits_o  (has_digits)
    );

    assign accept   = in_valid && in_ready_q;
    assign b_digit  = is_digit(in_data);
    assign b_dash   = (in_data == CH_DASH);
    assign b_delim  = (in_data == CH_COMMA) || (in_data == CH_LF);
    assign b_ignore = (in_data == CH_CR) || (in_data == CH_SP);

    always_comb begin
        state_d      = state_q;
        state_p      = state_q;
        hd_p         = has_digits;
        error_d      = error_q;
        start_save_d = start_save_q;
        acc_clear    = 1'b0;
        digit_v      = 1'b0;
        commit       = 1'b0;
        commit_end   = acc;
        wr_en        = 1'b0;
        count_d      = count_q;

        case (state_q)
            IDLE:   state_d = PARSE_START;
            FINISH: state_d = RUN;
            RUN:    state_d = RUN;
            PARSE_START, PARSE_END: begin
                if (accept) begin
                    if (b_digit) begin
                        digit_v = 1'b1;
                        hd_p    = 1'b1;
                    end else if (state_q == PARSE_START && b_dash && has_digits) begin
                        start_save_d = acc;
                        acc_clear    = 1'b1;
                        state_p      = PARSE_END;
                        hd_p         = 1'b0;
                    end else if (state_q == PARSE_END && b_delim && has_digits) begin
                        commit    = 1'b1;
                        acc_clear = 1'b1;
                        state_p   = PARSE_START;
                        hd_p      = 1'b0;
                    end else if (!(b_ignore || (b_delim && !has_digits))) begin
                        error_d = 1'b1;
                    end

                    // End of stream: judge the state left after this byte.
                    if (in_last) begin
                        if (state_p == PARSE_END && hd_p) begin
                            commit     = 1'b1;
                            commit_end = b_digit ? acc_nxt : acc;
                        end else if (hd_p || state_p == PARSE_END) begin
                            error_d = 1'b1;
                        end
                        acc_clear = 1'b1;
                        state_d   = FINISH;
                    end else begin
                        state_d = state_p;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // count_q doubles as the slot index: it always equals ranges stored.
        if (commit) begin
            if (count_q == CNT_W'(NUM_UNITS)) begin
                error_d = 1'b1;
            end else begin
                wr_en   = 1'b1;
                count_d = count_q + CNT_W'(1);
            end
        end

        // Outputs are registered from the next state so they track state_q exactly.
        in_ready_d = (state_d == PARSE_START) || (state_d == PARSE_END);
        load_d     = in_ready_d;
        en_d       = (state_d == RUN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b0;
            load_q       <= 1'b0;
            en_q         <= 1'b0;
            error_q      <= 1'b0;
            count_q      <= '0;
            start_save_q <= '0;
            for (int i = 0; i < NUM_UNITS; i++) begin
                start_id_q[i] <= '0;
                end_id_q[i]   <= '0;
            end
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            load_q       <= load_d;
            en_q         <= en_d;
            error_q      <= error_d;
            count_q      <= count_d;
            start_save_q <= start_save_d;
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (wr_en && count_q == CNT_W'(i)) begin
                    start_id_q[i] <= start_save_q;
                    end_id_q[i]   <= commit_end;
                end
            end
        end
    end

    assign in_ready    = in_ready_q;
    assign load        = load_q;
    assign en          = en_q;
    assign error       = error_q;
    assign range_count = count_q;
    assign start_id    = start_id_q;
    assign end_id      = end_id_q;

endmodule

// File: tb/tb_day2_range_loader.sv
// Directed bench: two loaders (4 and 2 slots) share one byte stream.
module tb_day2_range_loader;

    localparam int W = 48;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_last = 1'b0;

    logic          in_ready_a, load_a, en_a, error_a;
    logic [2:0]    count_a;
    logic [W-1:0]  start_a [4];
    logic [W-1:0]  end_a   [4];

    logic          in_ready_b, load_b, en_b, error_b;
    logic [1:0]    count_b;
    logic [W-1:0]  start_b [2];
    logic [W-1:0]  end_b   [2];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clock = ~clock;

    day2_range_loader #(.W(W), .NUM_UNITS(4)) dut_a (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_last(in_last), .start_id(start_a), .end_id(end_a),
        .load(load_a), .en(en_a), .range_count(count_a), .error(error_a)
    );

    day2_range_loader #(.W(W), .NUM_UNITS(2)) dut_b (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_last(in_last), .start_id(start_b), .end_id(end_b),
        .load(load_b), .en(en_b), .range_count(count_b), .error(error_b)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic release_reset();
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        while (!in_ready_a && guard < 50) begin
            @(posedge clock);
            #1;
            guard++;
        end
        if (guard >= 50) check_val("ready_timeout", 64'(in_ready_a), 64'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_str(input string s, input logic last_at_end, input logic gap);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], last_at_end && (i == s.len() - 1));
            if (gap) begin
                @(posedge clock);
                #1;
            end
        end
    endtask

    task automatic settle();
        repeat (3) @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset values while reset is held
        do_reset();
        check_val("rst_ready", 64'(in_ready_a), 64'd0);
        check_val("rst_load", 64'(load_a), 64'd0);
        check_val("rst_en", 64'(en_a), 64'd0);
        check_val("rst_error", 64'(error_a), 64'd0);
        check_val("rst_count", 64'(count_a), 64'd0);
        check_val("rst_start3", 64'(start_a[3]), 64'd0);
        release_reset();
        check_val("idle_ready", 64'(in_ready_a), 64'd1);
        check_val("idle_load", 64'(load_a), 64'd1);

        // "11-22,95-115\n": exact load/en timing after the final byte
        send_str("11-22,95-115\n", 1'b1, 1'b0);
        check_val("t1_fin_load", 64'(load_a), 64'd0);
        check_val("t1_fin_en", 64'(en_a), 64'd0);
        check_val("t1_fin_ready", 64'(in_ready_a), 64'd0);
        @(posedge clock);
        #1;
        check_val("t1_run_en", 64'(en_a), 64'd1);
        check_val("t1_run_load", 64'(load_a), 64'd0);
        check_val("t1_s0", 64'(start_a[0]), 64'd11);
        check_val("t1_e0", 64'(end_a[0]), 64'd22);
        check_val("t1_s1", 64'(start_a[1]), 64'd95);
        check_val("t1_e1", 64'(end_a[1]), 64'd115);
        check_val("t1_s2", 64'(start_a[2]), 64'd0);
        check_val("t1_e3", 64'(end_a[3]), 64'd0);
        check_val("t1_count", 64'(count_a), 64'd2);
        check_val("t1_error", 64'(error_a), 64'd0);
        settle();
        check_val("t1_en_held", 64'(en_a), 64'd1);

        // Large values, implicit commit on the last digit
        do_reset();
        release_reset();
        send_str("527473787-527596071", 1'b1, 1'b0);
        settle();
        check_val("t2_s0", 64'(start_a[0]), 64'd527473787);
        check_val("t2_e0", 64'(end_a[0]), 64'd527596071);
        check_val("t2_count", 64'(count_a), 64'd1);
        check_val("t2_error", 64'(error_a), 64'd0);
        check_val("t2_en", 64'(en_a), 64'd1);

        // Gapped valid
        do_reset();
        release_reset();
        send_str("1-2,3-4", 1'b1, 1'b1);
        settle();
        check_val("t3_s0", 64'(start_a[0]), 64'd1);
        check_val("t3_e0", 64'(end_a[0]), 64'd2);
        check_val("t3_s1", 64'(start_a[1]), 64'd3);
        check_val("t3_e1", 64'(end_a[1]), 64'd4);
        check_val("t3_count", 64'(count_a), 64'd2);
        check_val("t3_error", 64'(error_a), 64'd0);

        // Slot overflow on the 2-slot loader; the 4-slot one keeps all three
        do_reset();
        release_reset();
        send_str("1-2,3-4,5-6", 1'b1, 1'b0);
        settle();
        check_val("t4_b_s0", 64'(start_b[0]), 64'd1);
        check_val("t4_b_e0", 64'(end_b[0]), 64'd2);
        check_val("t4_b_s1", 64'(start_b[1]), 64'd3);
        check_val("t4_b_e1", 64'(end_b[1]), 64'd4);
        check_val("t4_b_count", 64'(count_b), 64'd2);
        check_val("t4_b_error", 64'(error_b), 64'd1);
        check_val("t4_b_en", 64'(en_b), 64'd1);
        check_val("t4_a_count", 64'(count_a), 64'd3);
        check_val("t4_a_e2", 64'(end_a[2]), 64'd6);
        check_val("t4_a_error", 64'(error_a), 64'd0);

        // Bad byte dropped, trailing partial range discarded
        do_reset();
        release_reset();
        send_str("1x-2,3-", 1'b1, 1'b0);
        settle();
        check_val("t5_error", 64'(error_a), 64'd1);
        check_val("t5_s0", 64'(start_a[0]), 64'd1);
        check_val("t5_e0", 64'(end_a[0]), 64'd2);
        check_val("t5_s1", 64'(start_a[1]), 64'd0);
        check_val("t5_count", 64'(count_a), 64'd1);
        check_val("t5_en", 64'(en_a), 64'd1);

        // Ignored CR, stray delimiter without digits
        do_reset();
        release_reset();
        send_str("5-6,\r\n", 1'b1, 1'b0);
        settle();
        check_val("t6_e0", 64'(end_a[0]), 64'd6);
        check_val("t6_count", 64'(count_a), 64'd1);
        check_val("t6_error", 64'(error_a), 64'd0);

        // Reset mid-stream, then a fresh parse
        do_reset();
        release_reset();
        send_str("12-3", 1'b0, 1'b0);
        do_reset();
        check_val("t7_rst_ready", 64'(in_ready_a), 64'd0);
        check_val("t7_rst_load", 64'(load_a), 64'd0);
        check_val("t7_rst_count", 64'(count_a), 64'd0);
        release_reset();
        send_str("7-8", 1'b1, 1'b0);
        settle();
        check_val("t7_s0", 64'(start_a[0]), 64'd7);
        check_val("t7_e0", 64'(end_a[0]), 64'd8);
        check_val("t7_count", 64'(count_a), 64'd1);
        check_val("t7_error", 64'(error_a), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/day2_range_loader.md
Name: day2_range_loader

Overview:
- Streams the ASCII puzzle-input text for day 2 ("a-b,c-d,...", optional trailing newline) one byte per cycle and parses the decimal ranges.
- Writes the parsed ranges into the parallel start_id/end_id arrays consumed by day2_puzzle.
- Drives day2_puzzle's load/en pair, replacing file-based loading, so the full puzzle flow runs on hardware from a byte source (UART/AXI-Stream bridge).

Parameters:
- W, 48, bit width of each parsed ID; matches day2_puzzle W.
- NUM_UNITS, 38, number of range slots; matches day2_puzzle NUM_UNITS.
- CNT_W, $clog2(NUM_UNITS+1), width of range_count.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  byte stream valid
- in_ready  out  1  byte accepted when in_valid && in_ready
- in_data  in  8  ASCII byte
- in_last  in  1  marks final byte of the stream
- start_id  out  W x NUM_UNITS  parsed range starts
- end_id  out  W x NUM_UNITS  parsed range ends
- load  out  1  high while arrays are being filled
- en  out  1  high once parsing completes; held until reset
- range_count  out  CNT_W  number of complete ranges stored
- error  out  1  sticky parse or overflow error

Behaviour:
- Clocking and reset: one clock; synchronous active-high reset. All outputs are registered.
- Reset values: state=IDLE; in_ready, load, en and error = 0; range_count = 0; accumulator, saved start and slot index = 0; every start_id[i] and end_id[i] = 0. Zero-filled unused slots give empty ranges that contribute 0 to the sum.
- Reset mid-stream aborts parsing and restores all reset values on the next edge.
- States:
  - IDLE: go to PARSE_START next cycle; load and in_ready become 1.
  - PARSE_START: digit => acc = acc*10 + (byte-'0'). '-' with at least one digit => save acc as start, clear acc, go to PARSE_END. '-' with no digit => error.
  - PARSE_END: digit => accumulate. ',' or '\n' with at least one digit => commit the range, clear acc, go to PARSE_START.
  - FINISH: one cycle with load=0, in_ready=0, en=0.
  - RUN: en=1, in_ready=0; terminal until reset.
- Commit: start_id[idx] <= saved start, end_id[idx] <= acc, idx++, range_count++. Arrays update on the edge after the delimiter is accepted.
- Ignored bytes in both parse states: '\r', ' ', and a ',' or '\n' arriving with no pending digits.
- Any other byte: error <= 1; the byte is dropped and the state is unchanged.
- in_last on an accepted byte: process the byte, then:
  - In PARSE_END with digits pending, commit implicitly.
  - In PARSE_START with digits pending, or in PARSE_END with no digits, set error and discard the partial range.
  - Then go to FINISH.
- Arithmetic: acc*10 is computed as (acc<<3)+(acc<<1), truncated modulo 2^W. There is no overflow detection on value wraparound.
- Slot overflow: a commit when idx==NUM_UNITS sets error, drops the range and leaves the arrays unchanged; parsing continues.
- Throughput: one byte per cycle; in_ready is constant within each state and does not depend on in_valid.
- Latency: en rises 2 cycles after the in_last byte is accepted (FINISH, then RUN). Arrays are stable from FINISH onward.
- load drops exactly one cycle before en rises, matching day2_puzzle's load-then-enable sequencing.

Decomposition:
- Package day2_pkg: loader_state_t enum (IDLE, PARSE_START, PARSE_END, FINISH, RUN); ASCII constants CH_0, CH_9, CH_DASH, CH_COMMA, CH_LF, CH_CR, CH_SP.
- One sub-module, day2_dec_accum: W-bit decimal shift-accumulator with clear and digit-valid inputs and a has_digits flag. The top-level FSM and slot writer instantiate it once.

Test Plan:
- "11-22,95-115\n" with in_last on '\n', NUM_UNITS=4 -> start_id={11,95,0,0}, end_id={22,115,0,0}, range_count=2, error=0; en=1 exactly 2 cycles after the last byte and load=0 one cycle before that.
- "527473787-527596071" with no delimiter, in_last on '1' -> slot0=527473787/527596071, range_count=1, error=0.
- in_valid toggled every other cycle on "1-2,3-4" -> same result as a continuous stream; no byte lost or duplicated.
- NUM_UNITS=2, "1-2,3-4,5-6" -> slots 1-2 and 3-4 stored, range_count=2, error=1, en still asserts.
- "1x-2,3-" with in_last on '-' -> error=1; slot0 = 1/2 with 'x' dropped; the trailing partial range is discarded; range_count=1.
- reset pulsed after "12-3" mid-stream -> all outputs return to reset values; a following "7-8" gives slot0=7/8, range_count=1.
